// File: rtl/conv_ifmap_feeder.sv
// Feature-SRAM feeder for the conv datapath: loads the 3x3 kernel, pulses
// conv_start, streams the ifmap row-major through a 2-entry FIFO, then waits for conv_done.
module conv_ifmap_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DIM_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDR_W-1:0]     cfg_kbase,
  input  logic [ADDR_W-1:0]     cfg_ibase,
  input  logic [DIM_W-1:0]      cfg_width,
  input  logic [DIM_W-1:0]      cfg_height,
  input  logic [DIM_W-1:0]      cfg_pitch,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [9*DATA_W-1:0]   kernel_num,
  output logic                  conv_start,
  output logic                  ifmap_valid,
  output logic [DATA_W-1:0]     ifmap_data,
  input  logic                  ifmap_ready,
  input  logic                  conv_done,
  output logic                  busy,
  output logic                  feeder_done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_START, S_STREAM, S_WAIT_DONE} state_e;

  state_e               state_q;
  logic [3:0]           kcnt_q;
  logic [ADDR_W-1:0]    addr_q, ibase_q, row_base_q;
  logic [DIM_W-1:0]     width_q, height_q, pitch_q, row_q, col_q;
  logic [8*DATA_W-1:0]  shadow_q;
  logic [9*DATA_W-1:0]  kernel_q;
  logic                 rd_pend_q, done_lat_q, conv_start_q, feeder_done_q, cfg_err_q;
  logic                 v0_q, v1_q, v0_d, v1_d;
  logic [DATA_W-1:0]    d0_q, d1_q, d0_d, d1_d;

  logic       pop, more_rd, issue, load_rd, last_pop, done_seen, cfg_bad;
  logic [2:0] occ;

  // Read issue keeps buffered + in-flight words at or below two.
  always_comb begin
    pop       = v0_q & ifmap_ready;
    occ       = 3'(v0_q) + 3'(v1_q) + 3'(rd_pend_q);
    more_rd   = (row_q != height_q);
    issue     = (state_q == S_STREAM) && more_rd && (occ < (3'd2 + 3'(pop)));
    load_rd   = (state_q == S_LOAD_K) && (kcnt_q < 4'd9);
    mem_en    = load_rd | issue;
    last_pop  = (state_q == S_STREAM) && !more_rd && !rd_pend_q && v0_q && !v1_q && pop;
    done_seen = done_lat_q | conv_done;
    cfg_bad   = (cfg_width < DIM_W'(3)) || (cfg_height < DIM_W'(3)) || (cfg_pitch < cfg_width);
  end

  // Shift FIFO: slot 0 is always the head, so valid/data come straight from flops.
  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    d0_d = d0_q;
    d1_d = d1_q;
    if (pop) begin
      v0_d = v1_q;
      d0_d = d1_q;
      v1_d = 1'b0;
    end
    if (rd_pend_q) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        d0_d = mem_rdata;
      end else begin
        v1_d = 1'b1;
        d1_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      kcnt_q        <= '0;
      addr_q        <= '0;
      ibase_q       <= '0;
      row_base_q    <= '0;
      width_q       <= '0;
      height_q      <= '0;
      pitch_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      shadow_q      <= '0;
      kernel_q      <= '0;
      rd_pend_q     <= 1'b0;
      done_lat_q    <= 1'b0;
      conv_start_q  <= 1'b0;
      feeder_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      v0_q          <= 1'b0;
      v1_q          <= 1'b0;
      d0_q          <= '0;
      d1_q          <= '0;
    end else begin
      conv_start_q  <= 1'b0;
      feeder_done_q <= 1'b0;
      rd_pend_q     <= issue;
      v0_q          <= v0_d;
      v1_q          <= v1_d;
      d0_q          <= d0_d;
      d1_q          <= d1_d;
      if (conv_done && (state_q inside {S_START, S_STREAM, S_WAIT_DONE}))
        done_lat_q <= 1'b1;
      // Row-base accumulator walks ibase + r*pitch + c without a multiplier.
      if (issue) begin
        if (col_q == width_q - DIM_W'(1)) begin
          col_q      <= '0;
          row_q      <= row_q + DIM_W'(1);
          row_base_q <= row_base_q + ADDR_W'(pitch_q);
          addr_q     <= row_base_q + ADDR_W'(pitch_q);
        end else begin
          col_q  <= col_q + DIM_W'(1);
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            ibase_q  <= cfg_ibase;
            width_q  <= cfg_width;
            height_q <= cfg_height;
            pitch_q  <= cfg_pitch;
            if (cfg_bad) begin
              cfg_err_q     <= 1'b1;
              feeder_done_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b0;
              kcnt_q    <= '0;
              addr_q    <= cfg_kbase;
              state_q   <= S_LOAD_K;
            end
          end
        end
        S_LOAD_K: begin
          kcnt_q <= kcnt_q + 4'd1;
          if (load_rd) addr_q <= addr_q + ADDR_W'(1);
          if (kcnt_q != 4'd0 && kcnt_q < 4'd9)
            shadow_q <= {mem_rdata, shadow_q[8*DATA_W-1:DATA_W]};
          if (kcnt_q == 4'd9) begin
            kernel_q     <= {mem_rdata, shadow_q};
            conv_start_q <= 1'b1;
            addr_q       <= ibase_q;
            row_base_q   <= ibase_q;
            row_q        <= '0;
            col_q        <= '0;
            state_q      <= S_START;
          end
        end
        S_START: state_q <= S_STREAM;
        S_STREAM: begin
          if (last_pop) begin
            state_q <= S_WAIT_DONE;
            if (done_seen) feeder_done_q <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (feeder_done_q) begin
            state_q    <= S_IDLE;
            done_lat_q <= 1'b0;
          end else if (done_seen) begin
            feeder_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr    = addr_q;
  assign kernel_num  = kernel_q;
  assign conv_start  = conv_start_q;
  assign ifmap_valid = v0_q;
  assign ifmap_data  = d0_q;
  assign busy        = (state_q != S_IDLE);
  assign feeder_done = feeder_done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_conv_ifmap_feeder.sv
// Randomized bench for conv_ifmap_feeder: SRAM model plus an address/pixel
// scoreboard built from ibase + r*pitch + c and the published latencies.
module tb_conv_ifmap_feeder;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DIM_W  = 8;

  logic                clk, rst, cfg_start, mem_en, conv_start, ifmap_valid, ifmap_ready;
  logic                conv_done, busy, feeder_done, cfg_err;
  logic [ADDR_W-1:0]   cfg_kbase, cfg_ibase, mem_addr;
  logic [DIM_W-1:0]    cfg_width, cfg_height, cfg_pitch;
  logic [DATA_W-1:0]   mem_rdata, ifmap_data;
  logic [9*DATA_W-1:0] kernel_num;

  logic [DATA_W-1:0]   mem [1024];
  logic [9*DATA_W-1:0] kern_now;
  int checks = 0;
  int errors = 0;

  conv_ifmap_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_kbase(cfg_kbase), .cfg_ibase(cfg_ibase),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_pitch(cfg_pitch),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .kernel_num(kernel_num),
    .conv_start(conv_start), .ifmap_valid(ifmap_valid), .ifmap_data(ifmap_data),
    .ifmap_ready(ifmap_ready), .conv_done(conv_done), .busy(busy),
    .feeder_done(feeder_done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM, one-cycle read latency; garbage when not enabled.
  always @(posedge clk) mem_rdata <= mem_en ? mem[mem_addr] : DATA_W'($urandom);

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_men"}, mem_en, 0);
    check({tag, "_maddr"}, mem_addr, 0);
    check({tag, "_kern"}, kernel_num, 0);
    check({tag, "_cs"}, conv_start, 0);
    check({tag, "_val"}, ifmap_valid, 0);
    check({tag, "_dat"}, ifmap_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fd"}, feeder_done, 0);
    check({tag, "_err"}, cfg_err, 0);
  endtask

  // rmode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random stalls.
  // dmode: 0 conv_done 6 cycles after last beat (plus one ignored in LOAD_K),
  //        1 conv_done at pixel 5 and a stray cfg_start at pixel 8.
  task automatic run(input logic [ADDR_W-1:0] kb, input logic [ADDR_W-1:0] ib,
                     input int w, input int h, input int p,
                     input int rmode, input int dmode, input int abort_pix);
    logic [ADDR_W-1:0]   exp_addr[$];
    logic [DATA_W-1:0]   exp_pix[$];
    logic [9*DATA_W-1:0] kexp;
    logic [ADDR_W-1:0]   a;
    logic [DATA_W-1:0]   pd;
    logic                pv, pr, fin, done_sent, ms_sent;
    int cyc, nrd, nbeat, ncs, nfd, fd_cyc, last_pop, issued_if, stall;
    kexp = '0;
    for (int k = 0; k < 9; k++) begin
      a = ADDR_W'(int'(kb) + k);
      exp_addr.push_back(a);
      kexp[k*DATA_W +: DATA_W] = mem[a];
    end
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        a = ADDR_W'(int'(ib) + r * p + c);
        exp_addr.push_back(a);
        exp_pix.push_back(mem[a]);
      end
    {pv, pr, fin, done_sent, ms_sent} = '0;
    pd = '0;
    {cyc, nrd, nbeat, ncs, nfd, fd_cyc, last_pop, issued_if, stall} = '0;
    @(negedge clk);
    cfg_kbase = kb; cfg_ibase = ib;
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_pitch = DIM_W'(p);
    cfg_start = 1'b1;
    ifmap_ready = 1'b1;
    conv_done = 1'b0;
    @(posedge clk);
    while (!fin && cyc < 600) begin
      @(negedge clk);
      cyc++;
      cfg_start = 1'b0;
      case (rmode)
        0: ifmap_ready = 1'b1;
        1: ifmap_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: begin
          if (stall > 0) begin
            ifmap_ready = 1'b0;
            stall--;
          end else begin
            ifmap_ready = 1'b1;
            stall = $urandom_range(0, 3);
          end
        end
      endcase
      conv_done = 1'b0;
      if (dmode == 0 && (cyc == 5 || (last_pop > 0 && cyc == last_pop + 6))) conv_done = 1'b1;
      if (dmode == 1 && nbeat == 5 && !done_sent) begin
        conv_done = 1'b1;
        done_sent = 1'b1;
      end
      if (dmode == 1 && nbeat == 8 && !ms_sent) begin
        cfg_start = 1'b1;
        cfg_width = DIM_W'(2);
        cfg_kbase = ADDR_W'(10'h155);
        ms_sent = 1'b1;
      end
      #1;
      if (abort_pix > 0 && nbeat == abort_pix) begin
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        kern_now = '0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          #1;
          check("post_abort_val", ifmap_valid, 0);
          check("post_abort_busy", busy, 0);
          check("post_abort_cs", conv_start, 0);
          check("post_abort_fd", feeder_done, 0);
          check("post_abort_men", mem_en, 0);
        end
        return;
      end
      if (mem_en) begin
        if (nrd < exp_addr.size()) check("rd_addr", mem_addr, exp_addr[nrd]);
        else check("rd_extra", 1, 0);
        if (nrd < 9) check("kread_cyc", cyc, nrd + 1);
        if (nrd == 9) check("first_rd_cyc", cyc, 12);
        nrd++;
        if (nrd > 9) issued_if++;
      end
      if (conv_start) begin
        ncs++;
        check("cs_cyc", cyc, 11);
      end
      if (cyc == 1) check("err_clr", cfg_err, 0);
      if (cyc == 10) check("kern_hold", kernel_num, kern_now);
      if (cyc == 11) begin
        check("kern", kernel_num, kexp);
        kern_now = kexp;
      end
      if (pv && !pr) begin
        check("hold_v", ifmap_valid, 1);
        check("hold_d", ifmap_data, pd);
      end
      if (ifmap_valid && ifmap_ready) begin
        if (nbeat < exp_pix.size()) check("pix", ifmap_data, exp_pix[nbeat]);
        else check("beat_extra", 1, 0);
        if (rmode == 0) check("beat_cyc", cyc, 14 + nbeat);
        nbeat++;
        if (nbeat == w * h) last_pop = cyc;
      end
      check("outstanding", (issued_if - nbeat) <= 2, 1);
      if (feeder_done) begin
        nfd++;
        fd_cyc = cyc;
      end
      if (nfd > 0 && cyc == fd_cyc + 1) begin
        check("busy_low", busy, 0);
        fin = 1'b1;
      end else begin
        check("busy_hi", busy, 1);
      end
      pv = ifmap_valid; pr = ifmap_ready; pd = ifmap_data;
    end
    check("timeout", fin, 1);
    check("n_rd", nrd, 9 + w * h);
    check("n_beat", nbeat, w * h);
    check("n_cs", ncs, 1);
    check("n_fd", nfd, 1);
    check("fd_cyc", fd_cyc, (dmode == 0) ? last_pop + 7 : last_pop + 1);
    check("cfg_err_end", cfg_err, 0);
  endtask

  task automatic run_bad(input int w, input int h, input int p);
    @(negedge clk);
    cfg_kbase = '0; cfg_ibase = '0;
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_pitch = DIM_W'(p);
    cfg_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      check("bad_fd", feeder_done, cyc == 1);
      check("bad_err", cfg_err, 1);
      check("bad_men", mem_en, 0);
      check("bad_cs", conv_start, 0);
      check("bad_busy", busy, 0);
    end
  endtask

  initial begin
    int w, h;
    rst = 1'b1; cfg_start = 1'b0; ifmap_ready = 1'b0; conv_done = 1'b0;
    cfg_kbase = '0; cfg_ibase = '0; cfg_width = '0; cfg_height = '0; cfg_pitch = '0;
    kern_now = '0;
    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
    for (int k = 0; k < 9; k++) mem[k] = DATA_W'(k + 1);
    for (int i = 0; i < 16; i++) mem[16 + i] = DATA_W'(16'h100 + i);
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("idle");

    run(10'h000, 10'h010, 4, 4, 4, 0, 0, 0);
    run(10'h200, 10'h3FC, 3, 3, 8, 0, 0, 0);
    run(10'h000, 10'h010, 4, 4, 4, 1, 0, 0);
    run(10'h000, 10'h010, 4, 4, 4, 2, 0, 0);
    run(10'h000, 10'h010, 4, 4, 4, 0, 1, 0);
    run(10'h000, 10'h010, 4, 4, 4, 2, 1, 0);
    for (int t = 0; t < 3; t++) begin
      w = $urandom_range(3, 6);
      h = $urandom_range(3, 6);
      run(ADDR_W'($urandom), ADDR_W'($urandom), w, h, w + $urandom_range(0, 3),
          2, $urandom_range(0, 1), 0);
    end
    run_bad(2, 4, 4);
    run(10'h000, 10'h010, 4, 4, 4, 2, 0, 0);
    run_bad(4, 4, 3);
    run_bad(4, 2, 4);
    run(10'h000, 10'h010, 4, 4, 4, 0, 0, 0);
    run(10'h000, 10'h010, 4, 4, 4, 0, 0, 7);
    for (int k = 0; k < 9; k++) mem[k] = DATA_W'(16'h0A0 + k);
    run(10'h000, 10'h010, 4, 4, 4, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
